// File: rtl/router_packet_reader.sv
// Destination-side reader for one router output port: pulls header, payload and parity
// out of the port FIFO, streams the payload and reports parity status. Define
// ROUTER_READER_STATS_EN to add saturating good/bad/abort packet counters.
module router_packet_reader #(
  parameter int DATA_WIDTH  = 8,
  parameter int START_DELAY = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  vld_out,
  input  logic                  soft_reset,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  read_enb,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_sop,
  output logic                  rx_eop,
  output logic [1:0]            pkt_addr,
  output logic [5:0]            pkt_len,
  output logic                  pkt_done,
  output logic                  pkt_err,
  output logic                  pkt_abort,
  output logic                  busy
`ifdef ROUTER_READER_STATS_EN
  ,
  output logic [15:0]           good_cnt,
  output logic [15:0]           bad_cnt,
  output logic [15:0]           abort_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_READ = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [4:0] DLY_LOAD = (START_DELAY > 0) ? 5'(START_DELAY - 1) : 5'd0;

  function automatic logic [DATA_WIDTH-1:0] parity_fold(
    input logic [DATA_WIDTH-1:0] acc,
    input logic [DATA_WIDTH-1:0] dat
  );
    return acc ^ dat;
  endfunction

  state_e                state_r, state_nxt_s;
  logic [4:0]            dly_cnt_r, dly_cnt_nxt_s;
  logic [6:0]            issue_left_r, issue_left_nxt_s;
  logic [6:0]            rcv_idx_r, rcv_idx_nxt_s;
  logic                  pending_r;
  logic [DATA_WIDTH-1:0] parity_acc_r, parity_acc_nxt_s;
  logic [1:0]            pkt_addr_r, pkt_addr_nxt_s;
  logic [5:0]            pkt_len_r, pkt_len_nxt_s;
  logic [DATA_WIDTH-1:0] rx_data_r, rx_data_nxt_s;
  logic                  rx_valid_r, rx_valid_nxt_s;
  logic                  rx_sop_r, rx_sop_nxt_s;
  logic                  rx_eop_r, rx_eop_nxt_s;
  logic                  pkt_done_r, pkt_done_nxt_s;
  logic                  pkt_err_r, pkt_err_nxt_s;
  logic                  pkt_abort_r, pkt_abort_nxt_s;
  logic                  busy_r;

  logic                  abort_s;
  logic                  hdr_cap_s;
  logic                  pay_cap_s;
  logic                  par_cap_s;
  logic [6:0]            len_ext_s;
  logic [6:0]            hdr_len_add_s;

  assign abort_s       = soft_reset && (state_r != S_IDLE);
  assign len_ext_s     = {1'b0, pkt_len_r};
  // A capture is the byte belonging to last cycle's read; rcv_idx says which byte it is.
  assign hdr_cap_s     = (state_r == S_READ) && pending_r && (rcv_idx_r == 7'd0);
  assign pay_cap_s     = (state_r == S_READ) && pending_r && (rcv_idx_r != 7'd0) &&
                         (rcv_idx_r <= len_ext_s);
  assign par_cap_s     = (state_r == S_READ) && pending_r && (rcv_idx_r == (len_ext_s + 7'd1));
  assign hdr_len_add_s = hdr_cap_s ? {1'b0, data_out[7:2]} : 7'd0;

  assign read_enb = (state_r == S_READ) && vld_out && (issue_left_r != 7'd0) && !soft_reset;

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state decode; an abort overrides every other transition.
  always_comb begin
    state_nxt_s = state_r;
    if (abort_s) begin
      state_nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (vld_out) begin
            state_nxt_s = (START_DELAY == 0) ? S_READ : S_WAIT;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_WAIT: begin
          if (!vld_out) begin
            state_nxt_s = S_IDLE;
          end else if (dly_cnt_r <= 5'd1) begin
            state_nxt_s = S_READ;
          end else begin
            state_nxt_s = S_WAIT;
          end
        end
        S_READ: begin
          if (par_cap_s) begin
            state_nxt_s = S_DONE;
          end else begin
            state_nxt_s = S_READ;
          end
        end
        S_DONE:  state_nxt_s = S_IDLE;
        default: state_nxt_s = S_IDLE;
      endcase
    end
  end

  // Next values of counters, packet fields and registered outputs.
  always_comb begin
    dly_cnt_nxt_s    = dly_cnt_r;
    issue_left_nxt_s = issue_left_r;
    rcv_idx_nxt_s    = rcv_idx_r;
    parity_acc_nxt_s = parity_acc_r;
    pkt_addr_nxt_s   = pkt_addr_r;
    pkt_len_nxt_s    = pkt_len_r;
    rx_data_nxt_s    = {DATA_WIDTH{1'b0}};
    rx_valid_nxt_s   = 1'b0;
    rx_sop_nxt_s     = 1'b0;
    rx_eop_nxt_s     = 1'b0;
    pkt_done_nxt_s   = 1'b0;
    pkt_err_nxt_s    = 1'b0;
    pkt_abort_nxt_s  = 1'b0;
    if (abort_s) begin
      dly_cnt_nxt_s    = 5'd0;
      issue_left_nxt_s = 7'd0;
      rcv_idx_nxt_s    = 7'd0;
      parity_acc_nxt_s = {DATA_WIDTH{1'b0}};
      pkt_abort_nxt_s  = 1'b1;
    end else begin
      case (state_r)
        S_IDLE: begin
          // Header and parity are always present, so READ starts with two reads owed.
          if (vld_out) begin
            dly_cnt_nxt_s    = DLY_LOAD;
            issue_left_nxt_s = 7'd2;
            rcv_idx_nxt_s    = 7'd0;
          end else begin
            dly_cnt_nxt_s    = 5'd0;
          end
        end
        S_WAIT: begin
          issue_left_nxt_s = 7'd2;
          rcv_idx_nxt_s    = 7'd0;
          if (dly_cnt_r != 5'd0) begin
            dly_cnt_nxt_s = dly_cnt_r - 5'd1;
          end else begin
            dly_cnt_nxt_s = 5'd0;
          end
        end
        S_READ: begin
          issue_left_nxt_s = issue_left_r - {6'd0, read_enb} + hdr_len_add_s;
          if (pending_r) begin
            rcv_idx_nxt_s = rcv_idx_r + 7'd1;
          end else begin
            rcv_idx_nxt_s = rcv_idx_r;
          end
          if (hdr_cap_s) begin
            pkt_addr_nxt_s   = data_out[1:0];
            pkt_len_nxt_s    = data_out[7:2];
            parity_acc_nxt_s = data_out;
          end else if (pay_cap_s) begin
            rx_valid_nxt_s   = 1'b1;
            rx_data_nxt_s    = data_out;
            rx_sop_nxt_s     = (rcv_idx_r == 7'd1);
            rx_eop_nxt_s     = (rcv_idx_r == len_ext_s);
            parity_acc_nxt_s = parity_fold(parity_acc_r, data_out);
          end else if (par_cap_s) begin
            pkt_done_nxt_s   = 1'b1;
            pkt_err_nxt_s    = (parity_fold(parity_acc_r, data_out) != {DATA_WIDTH{1'b0}});
          end else begin
            parity_acc_nxt_s = parity_acc_r;
          end
        end
        S_DONE: begin
          dly_cnt_nxt_s = 5'd0;
        end
        default: begin
          dly_cnt_nxt_s = 5'd0;
        end
      endcase
    end
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dly_cnt_r    <= 5'd0;
      issue_left_r <= 7'd0;
      rcv_idx_r    <= 7'd0;
      pending_r    <= 1'b0;
      parity_acc_r <= {DATA_WIDTH{1'b0}};
      pkt_addr_r   <= 2'd0;
      pkt_len_r    <= 6'd0;
      rx_data_r    <= {DATA_WIDTH{1'b0}};
      rx_valid_r   <= 1'b0;
      rx_sop_r     <= 1'b0;
      rx_eop_r     <= 1'b0;
      pkt_done_r   <= 1'b0;
      pkt_err_r    <= 1'b0;
      pkt_abort_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      dly_cnt_r    <= dly_cnt_nxt_s;
      issue_left_r <= issue_left_nxt_s;
      rcv_idx_r    <= rcv_idx_nxt_s;
      pending_r    <= read_enb;
      parity_acc_r <= parity_acc_nxt_s;
      pkt_addr_r   <= pkt_addr_nxt_s;
      pkt_len_r    <= pkt_len_nxt_s;
      rx_data_r    <= rx_data_nxt_s;
      rx_valid_r   <= rx_valid_nxt_s;
      rx_sop_r     <= rx_sop_nxt_s;
      rx_eop_r     <= rx_eop_nxt_s;
      pkt_done_r   <= pkt_done_nxt_s;
      pkt_err_r    <= pkt_err_nxt_s;
      pkt_abort_r  <= pkt_abort_nxt_s;
      busy_r       <= (state_nxt_s != S_IDLE);
    end
  end

  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign rx_sop    = rx_sop_r;
  assign rx_eop    = rx_eop_r;
  assign pkt_addr  = pkt_addr_r;
  assign pkt_len   = pkt_len_r;
  assign pkt_done  = pkt_done_r;
  assign pkt_err   = pkt_err_r;
  assign pkt_abort = pkt_abort_r;
  assign busy      = busy_r;

`ifdef ROUTER_READER_STATS_EN
  logic [15:0] good_cnt_r, bad_cnt_r, abort_cnt_r;

  function automatic logic [15:0] sat_inc(input logic [15:0] val, input logic en);
    if (en && (val != 16'hFFFF)) begin
      return val + 16'd1;
    end else begin
      return val;
    end
  endfunction

  // Saturating per-outcome packet counters, driven by the registered status pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      good_cnt_r  <= 16'd0;
      bad_cnt_r   <= 16'd0;
      abort_cnt_r <= 16'd0;
    end else begin
      good_cnt_r  <= sat_inc(good_cnt_r, pkt_done_r && !pkt_err_r);
      bad_cnt_r   <= sat_inc(bad_cnt_r, pkt_done_r && pkt_err_r);
      abort_cnt_r <= sat_inc(abort_cnt_r, pkt_abort_r);
    end
  end

  assign good_cnt  = good_cnt_r;
  assign bad_cnt   = bad_cnt_r;
  assign abort_cnt = abort_cnt_r;
`endif

endmodule

// File: tb/tb_router_packet_reader.sv
// Directed, table-driven bench for router_packet_reader with a small behavioural port FIFO.
module tb_router_packet_reader;

  logic       clk = 1'b0;
  logic       resetn;
  logic       vld_out;
  logic       soft_reset;
  logic [7:0] data_out;
  logic       read_enb;
  logic [7:0] rx_data;
  logic       rx_valid, rx_sop, rx_eop;
  logic [1:0] pkt_addr;
  logic [5:0] pkt_len;
  logic       pkt_done, pkt_err, pkt_abort, busy;

  always #5 clk = ~clk;

  router_packet_reader #(.DATA_WIDTH(8), .START_DELAY(3)) dut (
    .clk(clk), .resetn(resetn), .vld_out(vld_out), .soft_reset(soft_reset),
    .data_out(data_out), .read_enb(read_enb), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_sop(rx_sop), .rx_eop(rx_eop), .pkt_addr(pkt_addr), .pkt_len(pkt_len),
    .pkt_done(pkt_done), .pkt_err(pkt_err), .pkt_abort(pkt_abort), .busy(busy)
  );

  typedef struct {
    logic [7:0] hdr;
    logic [7:0] base;
    bit         bad_par;
    int         gap_after;
    int         exp_first;
    int         exp_reads;
    int         exp_rx;
    int         exp_addr;
    int         exp_len;
    int         exp_err;
  } vec_t;

  vec_t vecs[5];

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] mem [256];
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int wr_cnt, rd_ptr, cyc, first_rd, rd_cnt, rd_bad;
  int sop_cnt, sop_idx, eop_cnt, eop_idx, done_cnt, abort_cnt, stray;
  int gap_after, gap_left;
  logic err_seen, re_s, busy_s, abort_s;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic clear_log();
    rx_q.delete();
    first_rd = -1; rd_cnt = 0; rd_bad = 0;
    sop_cnt = 0; sop_idx = -1; eop_cnt = 0; eop_idx = -1;
    done_cnt = 0; abort_cnt = 0; stray = 0; err_seen = 1'b0;
    gap_after = -1; gap_left = 0; cyc = 0;
  endtask

  // Sample all DUT outputs mid-cycle; read_enb seen here is what the next edge samples.
  task automatic sample_phase();
    @(negedge clk);
    re_s = read_enb; busy_s = busy; abort_s = pkt_abort;
    if (read_enb) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
      if (!vld_out) rd_bad++;
    end
    if (rx_valid) begin
      if (rx_sop) begin sop_cnt++; sop_idx = rx_q.size(); end
      if (rx_eop) begin eop_cnt++; eop_idx = rx_q.size(); end
      rx_q.push_back(rx_data);
      if (rx_q.size() == gap_after) gap_left = 4;
    end else if (rx_sop || rx_eop) begin
      stray++;
    end
    if (pkt_done) begin done_cnt++; err_seen = pkt_err; end
    else if (pkt_err) stray++;
    if (pkt_abort) abort_cnt++;
  endtask

  // FIFO model: a read sampled at an edge presents its byte just after that edge.
  task automatic drive_phase();
    @(posedge clk);
    #1;
    cyc++;
    if (re_s) begin
      data_out = (rd_ptr < 256) ? mem[rd_ptr] : 8'h00;
      rd_ptr++;
    end
    if (gap_left > 0) begin
      gap_left--;
      vld_out = 1'b0;
    end else begin
      vld_out = (rd_ptr < wr_cnt);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin sample_phase(); drive_phase(); end
  endtask

  task automatic start_pkt(input logic [7:0] hdr, input logic [7:0] base,
                           input bit bad_par, input int gap);
    int len;
    logic [7:0] p, b;
    clear_log();
    exp_q.delete();
    len = int'(hdr[7:2]);
    mem[0] = hdr;
    p = hdr;
    for (int k = 0; k < len; k++) begin
      b = base + 8'(k * 17);
      mem[k + 1] = b;
      exp_q.push_back(b);
      p = p ^ b;
    end
    mem[len + 1] = bad_par ? 8'h00 : p;
    wr_cnt = len + 2;
    rd_ptr = 0;
    gap_after = gap;
    vld_out = 1'b1;
  endtask

  task automatic run_until_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      sample_phase(); drive_phase();
      if (done_cnt != 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic run_until_rx(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      sample_phase(); drive_phase();
      if (rx_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    bit ok;
    int bad;
    start_pkt(v.hdr, v.base, v.bad_par, v.gap_after);
    run_until_done(300, ok);
    chk({tag, "_timeout"}, int'(ok), 1);
    idle(3);
    bad = 0;
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      if (rx_q[i] != exp_q[i]) bad++;
    chk({tag, "_first_read_cycle"}, first_rd, v.exp_first);
    chk({tag, "_read_count"}, rd_cnt, v.exp_reads);
    chk({tag, "_read_while_empty"}, rd_bad, 0);
    chk({tag, "_rx_count"}, rx_q.size(), v.exp_rx);
    chk({tag, "_rx_data_errors"}, bad, 0);
    chk({tag, "_sop_count"}, sop_cnt, (v.exp_rx > 0) ? 1 : 0);
    chk({tag, "_eop_count"}, eop_cnt, (v.exp_rx > 0) ? 1 : 0);
    if (v.exp_rx > 0) begin
      chk({tag, "_sop_pos"}, sop_idx, 0);
      chk({tag, "_eop_pos"}, eop_idx, v.exp_rx - 1);
    end
    chk({tag, "_stray_flags"}, stray, 0);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_pkt_err"}, int'(err_seen), v.exp_err);
    chk({tag, "_abort_count"}, abort_cnt, 0);
    chk({tag, "_pkt_addr"}, int'(pkt_addr), v.exp_addr);
    chk({tag, "_pkt_len"}, int'(pkt_len), v.exp_len);
    chk({tag, "_busy_after"}, int'(busy_s), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    vecs[0] = '{hdr:8'h0D, base:8'h11, bad_par:1'b0, gap_after:-1, exp_first:3,
                exp_reads:5, exp_rx:3, exp_addr:1, exp_len:3, exp_err:0};
    vecs[1] = '{hdr:8'h0D, base:8'h11, bad_par:1'b1, gap_after:-1, exp_first:3,
                exp_reads:5, exp_rx:3, exp_addr:1, exp_len:3, exp_err:1};
    vecs[2] = '{hdr:8'h02, base:8'h00, bad_par:1'b0, gap_after:-1, exp_first:3,
                exp_reads:2, exp_rx:0, exp_addr:2, exp_len:0, exp_err:0};
    vecs[3] = '{hdr:8'h17, base:8'h40, bad_par:1'b0, gap_after:2, exp_first:3,
                exp_reads:7, exp_rx:5, exp_addr:3, exp_len:5, exp_err:0};
    vecs[4] = '{hdr:8'hFC, base:8'h05, bad_par:1'b0, gap_after:-1, exp_first:3,
                exp_reads:65, exp_rx:63, exp_addr:0, exp_len:63, exp_err:0};

    resetn = 1'b0; vld_out = 1'b0; soft_reset = 1'b0; data_out = 8'h00;
    wr_cnt = 0; rd_ptr = 0; re_s = 1'b0;
    clear_log();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", int'({read_enb, rx_valid, rx_sop, rx_eop, pkt_done, pkt_err,
                              pkt_abort, busy, pkt_addr, pkt_len, rx_data}), 0);
    resetn = 1'b1;

    // soft_reset while idle must not produce an abort
    soft_reset = 1'b1;
    sample_phase(); drive_phase();
    soft_reset = 1'b0;
    sample_phase();
    chk("idle_soft_reset_abort", int'(abort_s), 0);
    chk("idle_soft_reset_busy", int'(busy_s), 0);
    drive_phase();

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // soft_reset after the first payload byte of a len=8 packet
    start_pkt(8'h20, 8'h01, 1'b0, -1);
    run_until_rx(1, 100, ok);
    chk("sr_reach_byte1", int'(ok), 1);
    soft_reset = 1'b1;
    sample_phase();
    chk("sr_read_enb_same_cycle", int'(re_s), 0);
    chk("sr_busy_before", int'(busy_s), 1);
    drive_phase();
    soft_reset = 1'b0;
    rd_ptr = wr_cnt; vld_out = 1'b0;
    sample_phase();
    chk("sr_pkt_abort", int'(abort_s), 1);
    chk("sr_busy_after", int'(busy_s), 0);
    chk("sr_read_enb_after", int'(re_s), 0);
    drive_phase();
    idle(3);
    chk("sr_abort_pulses", abort_cnt, 1);
    chk("sr_no_done", done_cnt, 0);

    // asynchronous reset in the middle of a len=6 payload
    start_pkt(8'h1A, 8'h70, 1'b0, -1);
    run_until_rx(2, 100, ok);
    chk("rst_reach_byte2", int'(ok), 1);
    resetn = 1'b0;
    #1;
    chk("rst_mid_outputs", int'({read_enb, rx_valid, rx_sop, rx_eop, pkt_done, pkt_err,
                                pkt_abort, busy, pkt_addr, pkt_len, rx_data}), 0);
    rd_ptr = wr_cnt; vld_out = 1'b0;
    sample_phase(); drive_phase();
    resetn = 1'b1;
    idle(1);
    run_vec(vecs[0], "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/router_packet_reader.md
Name: router_packet_reader

Overview:
- Destination-side client that drains one 1x3 router output port.
- Watches the port's vld_out and drives read_enb to pull a complete packet out of the output FIFO: header, payload, parity.
- Reading starts within a bounded delay so the synchronizer's 30-cycle soft-reset timeout never fires on a healthy client.
- Presents payload bytes as a stream and reports per-packet completion and parity status. One instance per output port.

Parameters:
- DATA_WIDTH, 8, width of data_out and rx_data.
- START_DELAY, 3, cycles to wait after vld_out rises before the first read; legal range 0..20, must stay below the 30-cycle soft-reset timeout.

Ports:
- clk  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- vld_out  in  1  port FIFO non-empty, from synchronizer
- soft_reset  in  1  port soft reset from synchronizer; aborts the packet in progress
- data_out  in  DATA_WIDTH  FIFO read data, valid one cycle after a read_enb cycle
- read_enb  out  1  FIFO read strobe
- rx_data  out  DATA_WIDTH  payload byte
- rx_valid  out  1  rx_data qualifier, one cycle per payload byte
- rx_sop  out  1  with the first payload byte
- rx_eop  out  1  with the last payload byte
- pkt_addr  out  2  header[1:0] of current/last packet
- pkt_len  out  6  header[7:2] of current/last packet
- pkt_done  out  1  one-cycle pulse when the parity byte has been checked
- pkt_err  out  1  valid with pkt_done: 1 = parity mismatch
- pkt_abort  out  1  one-cycle pulse when soft_reset kills a packet
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (resetn=0, asynchronous): state IDLE.
  - All outputs 0.
  - All counters, parity accumulator, pkt_addr and pkt_len cleared to 0.
- Packet format: byte0 header = {len[5:0], addr[1:0]}; then len payload bytes (len 0..63 legal); then 1 parity byte.
  - Parity byte = XOR of header and all payload bytes.
- FIFO timing: data_out sampled at edge N+1 belongs to the read_enb=1 sampled at edge N.
  - Keep a 1-bit registered pending flag = read_enb delayed one cycle.
- read_enb rule: read_enb = (state==READ) && vld_out && (issue_left != 0). The block never reads an empty FIFO.
- States and transitions:
  - IDLE:
    - vld_out=1 and START_DELAY>0: load dly_cnt=START_DELAY-1, go to WAIT.
    - vld_out=1 and START_DELAY=0: go straight to READ.
  - WAIT: decrement dly_cnt; at 0 go to READ. If vld_out drops, return to IDLE.
  - READ: on entry issue_left=2 and rcv_idx=0 (header + parity are the minimum).
    - Each issued read decrements issue_left.
    - On the cycle the header is captured (pending && rcv_idx==0): latch pkt_addr and pkt_len, add len to issue_left, seed parity_acc=header.
      - The decrement and the add apply in the same cycle: next = issue_left - read_enb + len.
    - Each capture increments rcv_idx.
    - For 1 <= rcv_idx <= len: rx_valid=1, rx_data=byte, parity_acc ^= byte; rx_sop when rcv_idx==1; rx_eop when rcv_idx==len.
    - Capture at rcv_idx==len+1 is the parity byte: go to DONE.
  - DONE (one cycle): pkt_done=1, pkt_err=(parity_acc != parity byte, registered at capture); then IDLE.
    - If vld_out is already 1, the next packet follows via IDLE/WAIT again.
- len=0: no rx_valid, rx_sop or rx_eop; pkt_done follows the parity byte.
- vld_out low mid-packet: read_enb drops; the state holds; reading resumes when vld_out returns. A pending byte is still captured.
- soft_reset=1 in any state other than IDLE: next cycle state=IDLE, pkt_abort=1 for one cycle.
  - No pkt_done for that packet.
  - read_enb forced 0 in the same cycle soft_reset is high.
  - Counters cleared.
- soft_reset in IDLE: ignored.
- Simultaneous soft_reset and parity capture: soft_reset wins (abort, no pkt_done).
- rx_* and pkt_done/pkt_abort/pkt_err are registered outputs. pkt_addr and pkt_len hold until the next header.

Optional Feature:
- Macro: ROUTER_READER_STATS_EN.
- When defined, adds outputs good_cnt[15:0], bad_cnt[15:0], abort_cnt[15:0].
  - Incremented on pkt_done&&!pkt_err, pkt_done&&pkt_err, and pkt_abort respectively.
  - Counters saturate at 16'hFFFF and reset to 0 on resetn.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- START_DELAY=3; vld_out rises at cycle 0 with packet header 8'h0D (len=3, addr=1), payload 11,22,33, parity 8'h0D^8'h11^8'h22^8'h33.
  - First read_enb at cycle 3; exactly 5 read_enb cycles.
  - rx_data 11,22,33 with sop on 11 and eop on 33.
  - pkt_done=1, pkt_err=0; pkt_len=3, pkt_addr=1.
- Same packet with parity byte 8'h00 -> pkt_done=1 with pkt_err=1; payload still streamed.
- Header 8'h02 (len=0, addr=2), parity 8'h02 -> 2 reads, no rx_valid, pkt_done=1, pkt_err=0.
- len=5 packet with vld_out dropped for 4 cycles after payload byte 2 -> read_enb low during the gap, no bytes lost, pkt_err=0.
- soft_reset pulsed after payload byte 1 of a len=8 packet -> pkt_abort=1, no pkt_done, busy=0, read_enb=0 next cycle.
- resetn asserted mid-payload -> all outputs 0 immediately; a following clean packet completes with pkt_err=0.
